// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: shared states, error codes and defaults for the program loader
package prog_loader_pkg;
  typedef enum logic [2:0] {IDLE, LEN, DATA, CHK, DONE, ERR} state_t;
  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_CSUM = 2'd1;
  localparam logic [1:0] ERR_TMO  = 2'd2;
  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;
endpackage

// File: rtl/loader_timeout.sv
// loader_timeout: idle-cycle counter that flags expiry after CYC cycles without a clear; CYC=0 disables it
module loader_timeout #(
  parameter int CYC = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);
  localparam int W = CYC > 1 ? $clog2(CYC) : 1;
  logic [W-1:0] cnt;
  assign expire = (CYC != 0) && en && (cnt == W'(CYC - 1));
  always_ff @(posedge clk) begin
    if (rst || clr || !en) cnt <= '0;
    else if (!expire) cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/prog_loader.sv
// prog_loader: receives SYNC/LEN/data/CHK frames, writes program memory and gates the CPU reset
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE     = SYNC_DEFAULT,
  parameter logic [7:0] START_ADDR    = 8'h00,
  parameter int         TIMEOUT_CYC   = 1000,
  parameter bit         HOLD_AT_RESET = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       mem_we,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  output logic       cpu_hold,
  output logic       load_done,
  output logic       load_err,
  output logic [1:0] err_code
);
  state_t state, state_n;
  logic [8:0] cnt;
  logic [7:0] ptr, sum;
  logic acc, tmo, in_frame;
  // in_ready depends only on state and rst, never on in_valid
  assign in_ready  = !rst && (state inside {IDLE, LEN, DATA, CHK});
  assign acc       = in_valid && in_ready;
  assign in_frame  = state inside {LEN, DATA, CHK};
  assign load_done = state == DONE;
  assign load_err  = state == ERR;
  loader_timeout #(.CYC(TIMEOUT_CYC)) u_tmo (
    .clk(clk), .rst(rst), .clr(acc), .en(in_frame), .expire(tmo)
  );
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = (acc && in_data == SYNC_BYTE) ? LEN : IDLE;
      LEN:     state_n = acc ? DATA : tmo ? ERR : LEN;
      DATA:    state_n = acc ? (cnt == 9'd1 ? CHK : DATA) : tmo ? ERR : DATA;
      CHK:     state_n = acc ? (8'(sum + in_data) == 8'h00 ? DONE : ERR) : tmo ? ERR : CHK;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_we    <= 1'b0;
      mem_addr  <= 8'h00;
      mem_wdata <= 8'h00;
      cpu_hold  <= HOLD_AT_RESET;
      err_code  <= ERR_NONE;
      cnt       <= 9'd0;
      ptr       <= 8'h00;
      sum       <= 8'h00;
    end else begin
      mem_we <= acc && state == DATA;
      if (acc && state == LEN) begin
        cnt <= in_data == 8'h00 ? 9'd256 : {1'b0, in_data};
        ptr <= START_ADDR;
        sum <= 8'h00;
      end
      if (acc && state == DATA) begin
        mem_addr  <= ptr;
        mem_wdata <= in_data;
        ptr       <= ptr + 8'd1;
        sum       <= sum + in_data;
        cnt       <= cnt - 9'd1;
      end
      if (acc && state == IDLE && in_data == SYNC_BYTE) cpu_hold <= 1'b1;
      if (state == DONE) cpu_hold <= 1'b0;
      // an accept in the expiry cycle wins, so only a non-accept ERR entry is a timeout
      if (state_n == DONE) err_code <= ERR_NONE;
      if (state_n == ERR) err_code <= (tmo && !acc) ? ERR_TMO : ERR_CSUM;
    end
  end
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: randomized frame stimulus with a frame-level reference model and a decoupled scoreboard monitor
module tb_prog_loader;
  import prog_loader_pkg::*;
  localparam logic [7:0] START = 8'h80;
  localparam int TMO = 1000;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic in_ready, mem_we, cpu_hold, load_done, load_err;
  logic [7:0] mem_addr, mem_wdata;
  logic [1:0] err_code;
  int n_chk = 0, n_fail = 0;
  logic [15:0] wq[$];
  int rq[$];
  logic [7:0] s[$];

  prog_loader #(.START_ADDR(START), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .cpu_hold(cpu_hold),
    .load_done(load_done), .load_err(load_err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Frame-level model: parse the byte stream and queue expected writes and results
  task automatic model(input logic [7:0] st[$], input bit tail_tmo);
    int i, n, sum, a;
    i = 0;
    while (i < st.size()) begin
      if (st[i] != SYNC_DEFAULT) begin
        i++;
        continue;
      end
      if (i + 1 >= st.size()) begin
        if (tail_tmo) rq.push_back(2);
        return;
      end
      n = (st[i+1] == 8'h00) ? 256 : int'(st[i+1]);
      sum = 0;
      for (int k = 0; k < n && i + 2 + k < st.size(); k++) begin
        a = (int'(START) + k) % 256;
        wq.push_back({a[7:0], st[i+2+k]});
        sum += int'(st[i+2+k]);
      end
      if (i + 2 + n >= st.size()) begin
        if (tail_tmo) rq.push_back(2);
        return;
      end
      rq.push_back(((sum + int'(st[i+2+n])) % 256 == 0) ? 0 : 1);
      i += n + 3;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_data = b;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      if (++t > 3 * TMO) begin
        $display("FAIL ready_wait: in_ready stuck low, expected high");
        $fatal(1, "in_ready never rose");
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data = 8'($urandom);
  endtask

  task automatic send_stream(input logic [7:0] st[$], input bit tail_tmo);
    model(st, tail_tmo);
    foreach (st[i]) begin
      send_byte(st[i]);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic settle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_mem_we"}, mem_we, 0);
    check({tag, "_mem_addr"}, mem_addr, 0);
    check({tag, "_mem_wdata"}, mem_wdata, 0);
    check({tag, "_cpu_hold"}, cpu_hold, 1);
    check({tag, "_done"}, load_done, 0);
    check({tag, "_err"}, load_err, 0);
    check({tag, "_err_code"}, err_code, 0);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a write or a frame result
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      if (wq.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL write: got addr %0h data %0h, expected no write", mem_addr, mem_wdata);
      end else check("write", {mem_addr, mem_wdata}, wq.pop_front());
    end
    if (load_done === 1'b1 || load_err === 1'b1) begin
      if (rq.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL result: got done=%0b err=%0b code=%0d, expected none", load_done, load_err, err_code);
      end else begin
        int r;
        r = rq.pop_front();
        check("result", {load_done, load_err, err_code}, {r == 0, r != 0, 2'(r)});
      end
    end
  end

  initial begin
    logic [7:0] b;
    int n, sum;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    settle(1);
    check("idle_ready", in_ready, 1);

    s = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h9A};
    send_stream(s, 0);
    settle(3);
    check("t1_hold", cpu_hold, 0);
    check("t1_code", err_code, 0);

    s = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h9B};
    send_stream(s, 0);
    settle(3);
    check("t2_hold", cpu_hold, 1);
    check("t2_code", err_code, 1);

    s = '{8'h00, 8'h7E, 8'hA5, 8'h01, 8'h05, 8'hFB};
    send_stream(s, 0);
    settle(3);
    check("t3_hold", cpu_hold, 0);

    s = '{8'hA5, 8'h02, 8'h10};
    send_stream(s, 1);
    settle(TMO + 5);
    check("t4_tmo_seen", rq.size(), 0);
    check("t4_code", err_code, 2);
    check("t4_hold", cpu_hold, 1);
    s = '{8'hA5, 8'h01, 8'h07, 8'hF9};
    send_stream(s, 0);
    settle(3);
    check("t4_recover_code", err_code, 0);
    check("t4_recover_hold", cpu_hold, 0);

    s = '{8'hA5, 8'h00};
    for (int i = 0; i < 256; i++) s.push_back(8'(i));
    s.push_back(8'h80);
    send_stream(s, 0);
    settle(3);
    check("t5_code", err_code, 0);
    check("t5_hold", cpu_hold, 0);

    s = '{8'hA5, 8'h04, 8'h3C, 8'hC3};
    send_stream(s, 0);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_reset_outputs("t6");
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("t6_idle_ready", in_ready, 1);
    @(posedge clk);
    #1;
    s = '{8'hA5, 8'h02, 8'h40, 8'h41, 8'h7F};
    send_stream(s, 0);
    settle(3);
    check("t6_recover_hold", cpu_hold, 0);

    for (int f = 0; f < 25; f++) begin
      s = {};
      repeat ($urandom_range(0, 2)) begin
        b = 8'($urandom);
        s.push_back(b == 8'hA5 ? 8'h00 : b);
      end
      n = $urandom_range(1, 16);
      s.push_back(8'hA5);
      s.push_back(8'(n));
      sum = 0;
      repeat (n) begin
        b = 8'($urandom);
        s.push_back(b);
        sum += int'(b);
      end
      b = 8'((256 - sum % 256) % 256);
      if ($urandom_range(0, 9) < 3) b = b ^ 8'($urandom_range(1, 255));
      s.push_back(b);
      send_stream(s, 0);
    end
    settle(5);
    check("final_writes_drained", wq.size(), 0);
    check("final_results_drained", rq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
